seq_div_8by4: RTL and testbench

SEQ_DIV_8BY4 -- requirements
Module: seq_div_8by4

---
 rtl/seq_div_pkg.sv | 17 +
 rtl/div_step.sv | 44 ++++
 rtl/seq_div_8by4.sv | 156 +++++++++++++++
 tb/tb_seq_div_8by4.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// -----------------------------------------------------------------------------
// seq_div_pkg
// Shared definitions for the sequential 2N-by-N restoring divider:
//   DEFAULT_N : default divisor/remainder width (dividend/quotient is 2*N)
//   state_t   : controller state encoding (IDLE, BUSY, DONE)
// -----------------------------------------------------------------------------
package seq_div_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step. It shifts the next dividend bit
// into the partial remainder, compares against the divisor, and subtracts
// when the shifted remainder is large enough.
// Ports:
//   rem_in   [N:0]   partial remainder before the step
//   bit_in           next dividend bit (MSB first)
//   divisor  [N-1:0] divisor
//   rem_out  [N:0]   partial remainder after the step
//   q_bit            quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import seq_div_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N:0]   rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N:0] shifted;
    logic       unused_rem_msb;

    // The remainder entering a step is always below the divisor, so its MSB
    // carries no information and is dropped by the shift. With a zero divisor
    // the remainder simply becomes a window over the last N dividend bits.
    assign unused_rem_msb = rem_in[N];

    always_comb begin
        shifted = {rem_in[N-1:0], bit_in};
        if (shifted >= {1'b0, divisor}) begin
            q_bit   = 1'b1;
            rem_out = shifted - {1'b0, divisor};
        end else begin
            q_bit   = 1'b0;
            rem_out = shifted;
        end
    end

endmodule

// File: rtl/seq_div_8by4.sv
// -----------------------------------------------------------------------------
// seq_div_8by4
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock, MSB first. Fixed latency: done pulses 2*N+1 edges after the
// accepting edge. Results hold until the next accepted request.
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   A       [2N-1:0] dividend, captured on the accepting edge
//   B       [N-1:0]  divisor, captured on the accepting edge
//   start            request, level-sampled while idle
//   quotient[2N-1:0] registered quotient
//   remainder[N-1:0] registered remainder
//   busy             high while iterating
//   done             one-cycle pulse when results update
//   dbz              divide-by-zero flag, valid with done
// Configuration macro:
//   SEQ_DIV_DBZ_CHECK_EN - a zero divisor skips iteration and finishes one
//                          edge after acceptance with dbz=1. When undefined,
//                          dbz stays 0 and B=0 runs the normal iteration.
// -----------------------------------------------------------------------------
module seq_div_8by4
    import seq_div_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2*N-1:0] A,
    input  logic [N-1:0]   B,
    input  logic           start,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           dbz
);

    localparam int CNT_W = (2 * N > 1) ? $clog2(2 * N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * N - 1);

    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N:0]     rem_q, rem_d;
    logic [2*N-1:0] dvd_q, dvd_d;
    logic [N-1:0]   div_q, div_d;
    logic [2*N-1:0] quotient_q, quotient_d;
    logic [N-1:0]   remainder_q, remainder_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           dbz_q, dbz_d;

    logic [N:0]     step_rem;
    logic           step_qbit;

    div_step #(.N(N)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[2*N-1]),
        .divisor (div_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    // Next-state logic. The dividend register doubles as the quotient
    // register: each step shifts out the next dividend bit at the top and
    // shifts the new quotient bit in at the bottom, so after 2*N steps it
    // holds the full quotient.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        div_d       = div_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = A;
                    div_d   = B;
                    cnt_d   = '0;
                    rem_d   = '0;
                    state_d = BUSY;
`ifdef SEQ_DIV_DBZ_CHECK_EN
                    // Preload the zero-divisor answer so DONE can publish
                    // it exactly like a normal result.
                    if (B == '0) begin
                        dvd_d   = '1;
                        rem_d   = {1'b0, A[N-1:0]};
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[2*N-2:0], step_qbit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                quotient_d  = dvd_q;
                remainder_d = rem_q[N-1:0];
`ifdef SEQ_DIV_DBZ_CHECK_EN
                dbz_d       = (div_q == '0);
`endif
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == BUSY);
        done_d = (state_q == DONE);
    end

    // Single state register for the controller, datapath and registered
    // outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            div_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            div_q       <= div_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_div_8by4.sv
// -----------------------------------------------------------------------------
// tb_seq_div_8by4
// Directed scoreboard bench for seq_div_8by4 (N=4). Stimulus pushes the
// expected quotient/remainder/dbz and the edge on which done must appear;
// a monitor pops and compares every done pulse. Honors SEQ_DIV_DBZ_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_seq_div_8by4;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        int         edge_no;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] A;
    logic [3:0] B;
    logic       start;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       dbz;

    exp_t sb[$];
    int   edge_cnt;
    int   n_checks;
    int   n_pass;

`ifdef SEQ_DIV_DBZ_CHECK_EN
    localparam int  DBZ_LAT = 1;
    localparam logic DBZ_EXP = 1'b1;
`else
    localparam int  DBZ_LAT = 9;
    localparam logic DBZ_EXP = 1'b0;
`endif

    seq_div_8by4 #(.N(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .start     (start),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter used to timestamp acceptance and done edges.
    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (reset && done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("quotient", 32'(quotient), 32'(e.q));
                checkOutput("remainder", 32'(remainder), 32'(e.r));
                checkOutput("dbz", 32'(dbz), 32'(e.dbz));
                checkOutput("done_edge", 32'(edge_cnt), 32'(e.edge_no));
            end
        end
    end

    // Wait for all outstanding results; a stuck queue counts as a failure.
    task automatic waitDrain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    function automatic void pushExp(input logic [7:0] q, input logic [3:0] r,
                                    input logic d, input int edge_no);
        exp_t e;
        e.q = q; e.r = r; e.dbz = d; e.edge_no = edge_no;
        sb.push_back(e);
    endfunction

    // One request: pulse start for a single accepting edge, then check busy,
    // wait for the result and confirm the result holds afterwards.
    task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b,
                                 input logic [7:0] eq, input logic [3:0] er,
                                 input logic edbz, input int lat);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        pushExp(eq, er, edbz, edge_cnt + 1 + lat);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_accept", 32'(busy), (lat > 1) ? 32'd1 : 32'd0);
        waitDrain();
        repeat (3) @(negedge clk);
        checkOutput("hold_quotient", 32'(quotient), 32'(eq));
        checkOutput("hold_remainder", 32'(remainder), 32'(er));
    endtask

    initial begin
        int acc;
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b0;
        start = 1'b1;
        A = 8'h20;
        B = 4'h4;

        // Held in reset with start high: nothing may be accepted.
        repeat (3) @(negedge clk);
        checkOutput("reset_quotient", 32'(quotient), 32'd0);
        checkOutput("reset_remainder", 32'(remainder), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_dbz", 32'(dbz), 32'd0);

        // First accepting edge is the first one with reset released.
        reset = 1'b1;
        pushExp(8'h08, 4'h0, 1'b0, edge_cnt + 1 + 9);
        @(negedge clk);
        start = 1'b0;
        checkOutput("first_busy", 32'(busy), 32'd1);
        waitDrain();

        applyStimulus(8'hFF, 4'h2, 8'h7F, 4'h1, 1'b0, 9);
        applyStimulus(8'hE1, 4'hF, 8'h0F, 4'h0, 1'b0, 9);
        applyStimulus(8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 9);
        applyStimulus(8'h07, 4'h9, 8'h00, 4'h7, 1'b0, 9);
        applyStimulus(8'h2D, 4'h0, 8'hFF, 4'hD, DBZ_EXP, DBZ_LAT);
        applyStimulus(8'h20, 4'h4, 8'h08, 4'h0, 1'b0, 9);

        // Start and operand changes mid-iteration are ignored.
        @(negedge clk);
        A = 8'h09;
        B = 4'h3;
        start = 1'b1;
        acc = edge_cnt + 1;
        pushExp(8'h03, 4'h0, 1'b0, acc + 9);
        @(negedge clk);
        start = 1'b0;
        while (edge_cnt < acc + 4) @(negedge clk);
        A = 8'h03;
        B = 4'h1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDrain();
        repeat (12) @(negedge clk);

        // Reset mid-iteration abandons the operation.
        @(negedge clk);
        A = 8'h0F;
        B = 4'h3;
        start = 1'b1;
        acc = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        while (edge_cnt < acc + 3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("midreset_quotient", 32'(quotient), 32'd0);
        checkOutput("midreset_remainder", 32'(remainder), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_dbz", 32'(dbz), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        applyStimulus(8'h03, 4'h1, 8'h03, 4'h0, 1'b0, 9);

        // Start held high: back-to-back requests every 10 cycles.
        @(negedge clk);
        A = 8'h11;
        B = 4'h4;
        start = 1'b1;
        acc = edge_cnt + 1;
        pushExp(8'h04, 4'h1, 1'b0, acc + 9);
        pushExp(8'h04, 4'h1, 1'b0, acc + 19);
        pushExp(8'h04, 4'h1, 1'b0, acc + 29);
        while (edge_cnt < acc + 20) @(negedge clk);
        start = 1'b0;
        waitDrain();
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
